axis_weight_preload: RTL and testbench



---
 rtl/axis_weight_preload_pkg.sv | 24 ++
 rtl/axis_weight_preload_if.sv | 14 +
 rtl/axis_weight_preload_fifo.sv | 58 +++++
 rtl/axis_weight_preload.sv | 139 +++++++++++++
 tb/tb_axis_weight_preload.sv | 354 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/axis_weight_preload_pkg.sv
// Shared sizing helpers for the weight preload block: default geometry and clogb2.
package weight_preload_pkg;

   // Number of bits needed to hold 'value' (clogb2(3) = 2, clogb2(19) = 5).
   function automatic int clogb2(input int value);
      int v;
      int r;
      v = value;
      r = 0;
      while (v > 0) begin
         r = r + 1;
         v = v >> 1;
      end
      return r;
   endfunction

   localparam int MAC_NUM_DEF   = 256;
   localparam int AXIS_DW_DEF   = 64;
   localparam int FIFO_DEPTH_DEF = 4;
   localparam int W             = 5 * MAC_NUM_DEF;
   localparam int BEATS         = W / AXIS_DW_DEF;
   localparam int BEAT_CW       = clogb2(BEATS - 1) + 1;

endpackage

// File: rtl/axis_weight_preload_if.sv
// AXI4-Stream data channel between the DMA (master) and the weight preload block (slave).
interface axis_weight_preload_if #(
   parameter int DATA_W = 64
) ();
   // A beat transfers on a rising clk edge where tvalid && tready; tdata/tlast
   // are held stable by the master while tvalid is high and tready is low.
   logic [DATA_W-1:0] tdata;
   logic              tvalid;
   logic              tready;
   logic              tlast;

   modport master (output tdata, output tvalid, output tlast, input tready);
   modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/axis_weight_preload_fifo.sv
// Show-ahead (first-word-fall-through) word FIFO; head is combinational from registered state.
module weight_preload_fifo
   import weight_preload_pkg::*;
#(
   parameter int WIDTH = 1280,
   parameter int DEPTH = 4,
   localparam int PW = clogb2(DEPTH - 1),
   localparam int CW = clogb2(DEPTH - 1) + 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clear_i,
   input  logic             push_i,
   input  logic             pop_i,
   input  logic [WIDTH-1:0] data_i,
   output logic [WIDTH-1:0] data_o,
   output logic [CW-1:0]    count_o,
   output logic             full_o,
   output logic             empty_o
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
   logic [CW-1:0]    count_q;
   logic             pop_ok, push_ok;

   assign empty_o = (count_q == '0);
   assign full_o  = (count_q == CW'(DEPTH));
   assign pop_ok  = pop_i && !empty_o;
   // A push into a full FIFO is legal only when the same edge frees the head slot.
   assign push_ok = push_i && (!full_o || pop_ok);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else if (clear_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push_ok) wr_ptr_q <= wr_ptr_q + PW'(1);
         if (pop_ok)  rd_ptr_q <= rd_ptr_q + PW'(1);
         if (push_ok && !pop_ok)      count_q <= count_q + CW'(1);
         else if (pop_ok && !push_ok) count_q <= count_q - CW'(1);
      end
   end

   // Storage needs no reset: the output mux hides every slot while empty.
   always_ff @(posedge clk) begin
      if (push_ok && !clear_i) mem_q[wr_ptr_q] <= data_i;
   end

   assign data_o  = empty_o ? '0 : mem_q[rd_ptr_q];
   assign count_o = count_q;

endmodule

// File: rtl/axis_weight_preload.sv
// AXI4-Stream weight preload: packs narrow beats into 5*MAC_NUM-bit words and queues them.
// Optional status outputs (words_rcvd, err_short_pkt) are built with WEIGHT_PRELOAD_STATUS_EN.
module axis_weight_preload
   import weight_preload_pkg::*;
#(
   parameter int MAC_NUM                 = MAC_NUM_DEF,
   parameter int AXIS_DATA_WIDTH         = AXIS_DW_DEF,
   parameter int AXIS_PRELOAD_FIFO_DEPTH = FIFO_DEPTH_DEF,
   localparam int WORD_W  = 5 * MAC_NUM,
   localparam int bit_num = clogb2(AXIS_PRELOAD_FIFO_DEPTH - 1)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   axis_weight_preload_if.slave  s_axis,
   input  logic                  clear,
   input  logic                  fifo_read,
   output logic [WORD_W-1:0]     fifo_data,
   output logic [bit_num:0]      fifo_cnt,
   output logic [12:0]           words_rcvd,
   output logic                  err_short_pkt
);

   localparam int NBEATS = WORD_W / AXIS_DATA_WIDTH;
   localparam int BCW    = clogb2(NBEATS - 1) + 1;

   logic [BCW-1:0]    beat_cnt_q, beat_cnt_d;
   logic [WORD_W-1:0] asm_q, asm_d;
   logic              pending_q, pending_d;
   logic [WORD_W-1:0] base, merged, push_data;
   logic              push, accept, last_beat, word_done, room;
   logic              fifo_full, fifo_empty;

   assign last_beat = (beat_cnt_q == BCW'(NBEATS - 1));
   // pending_q: a short packet closed while the FIFO was full; the finished word
   // waits in the assembly register. Only registered terms feed tready.
   assign s_axis.tready = !((last_beat || pending_q) && fifo_full);
   assign accept        = s_axis.tvalid && s_axis.tready && !clear;
   assign word_done     = accept && (last_beat || s_axis.tlast);
   assign room          = !fifo_full || (fifo_read && !fifo_empty);

   always_comb begin
      base       = pending_q ? '0 : asm_q;
      merged     = base;
      merged[int'(beat_cnt_q)*AXIS_DATA_WIDTH +: AXIS_DATA_WIDTH] = s_axis.tdata;
      push       = 1'b0;
      push_data  = asm_q;
      pending_d  = pending_q;
      asm_d      = asm_q;
      beat_cnt_d = beat_cnt_q;

      if (pending_q && room) begin
         push      = 1'b1;
         push_data = asm_q;
         pending_d = 1'b0;
         asm_d     = '0;
      end

      if (accept) begin
         if (word_done) begin
            beat_cnt_d = '0;
            if (!push && room) begin
               push      = 1'b1;
               push_data = merged;
               asm_d     = '0;
            end else begin
               pending_d = 1'b1;
               asm_d     = merged;
            end
         end else begin
            beat_cnt_d = beat_cnt_q + BCW'(1);
            asm_d      = merged;
         end
      end

      // Flush wins over everything, including a beat handshaking this cycle.
      if (clear) begin
         push       = 1'b0;
         pending_d  = 1'b0;
         asm_d      = '0;
         beat_cnt_d = '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         beat_cnt_q <= '0;
         asm_q      <= '0;
         pending_q  <= 1'b0;
      end else begin
         beat_cnt_q <= beat_cnt_d;
         asm_q      <= asm_d;
         pending_q  <= pending_d;
      end
   end

   weight_preload_fifo #(
      .WIDTH (WORD_W),
      .DEPTH (AXIS_PRELOAD_FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .clear_i (clear),
      .push_i  (push),
      .pop_i   (fifo_read),
      .data_i  (push_data),
      .data_o  (fifo_data),
      .count_o (fifo_cnt),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

`ifdef WEIGHT_PRELOAD_STATUS_EN
   logic [12:0] words_q;
   logic        err_q;
   logic        short_set;

   assign short_set = word_done && !last_beat;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         words_q <= '0;
         err_q   <= 1'b0;
      end else if (clear) begin
         words_q <= '0;
         err_q   <= 1'b0;
      end else begin
         if (push)      words_q <= words_q + 13'd1;
         if (short_set) err_q   <= 1'b1;
      end
   end

   assign words_rcvd    = words_q;
   assign err_short_pkt = err_q;
`else
   assign words_rcvd    = '0;
   assign err_short_pkt = 1'b0;
`endif

endmodule

// File: tb/tb_axis_weight_preload.sv
// Randomized scoreboard bench for axis_weight_preload (default geometry: 20 beats of 64 bits, depth 4).
module tb_axis_weight_preload;

   localparam int ADW   = 64;
   localparam int W     = 1280;
   localparam int BEATS = 20;
   localparam int DEPTH = 4;

   logic            clk;
   logic            rst_n;
   logic            clear;
   logic            fifo_read;
   logic [W-1:0]    fifo_data;
   logic [2:0]      fifo_cnt;
   logic [12:0]     words_rcvd;
   logic            err_short_pkt;

   axis_weight_preload_if #(.DATA_W(ADW)) s_axis ();

   axis_weight_preload dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .s_axis        (s_axis),
      .clear         (clear),
      .fifo_read     (fifo_read),
      .fifo_data     (fifo_data),
      .fifo_cnt      (fifo_cnt),
      .words_rcvd    (words_rcvd),
      .err_short_pkt (err_short_pkt)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // reference model state
   logic [W-1:0]   exp_q [$];
   logic [ADW-1:0] beat_buf [$];
   int             exp_words;
   bit             exp_err;
   bit             sb_en;
   bit             rand_done;
   int             checks;
   int             errors;

   function automatic logic [W-1:0] build_word();
      logic [W-1:0] w;
      w = '0;
      for (int k = 0; k < beat_buf.size(); k++) w[k*ADW +: ADW] = beat_buf[k];
      return w;
   endfunction

   task automatic check64(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic check_word(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got lo=%h hi=%h expected lo=%h hi=%h at %0t",
                  name, act[63:0], act[W-1 -: 64], exp[63:0], exp[W-1 -: 64], $time);
      end
   endtask

   task automatic model_flush();
      exp_q.delete();
      beat_buf.delete();
      exp_words = 0;
      exp_err   = 1'b0;
   endtask

   // driver tasks: all start and return at posedge+1
   task automatic send_beat(input logic [ADW-1:0] d, input bit last);
      int n;
      n = 0;
      s_axis.tdata  = d;
      s_axis.tlast  = last;
      s_axis.tvalid = 1'b1;
      @(negedge clk);
      while (!s_axis.tready && n < 300) begin
         n++;
         @(negedge clk);
      end
      if (!s_axis.tready) begin
         checks++;
         errors++;
         $display("FAIL handshake_timeout: tready stuck at 0 at %0t", $time);
         @(posedge clk);
         #1;
         s_axis.tvalid = 1'b0;
         s_axis.tlast  = 1'b0;
         return;
      end
      @(posedge clk);
      #1;
      s_axis.tvalid = 1'b0;
      s_axis.tlast  = 1'b0;
      beat_buf.push_back(d);
      if (last || beat_buf.size() == BEATS) begin
         if (beat_buf.size() < BEATS) exp_err = 1'b1;
         exp_q.push_back(build_word());
         exp_words = (exp_words + 1) % 8192;
         beat_buf.delete();
      end
   endtask

   task automatic send_word_rand();
      for (int k = 0; k < BEATS; k++) send_beat({$urandom, $urandom}, k == BEATS - 1);
   endtask

   task automatic wait_room();
      int n;
      n = 0;
      while (exp_q.size() >= DEPTH && n < 500) begin
         @(posedge clk);
         #1;
         n++;
      end
      if (exp_q.size() >= DEPTH) begin
         checks++;
         errors++;
         $display("FAIL wait_room_timeout: fifo stayed full at %0t", $time);
      end
   endtask

   task automatic drain();
      int n;
      n = 0;
      fifo_read = 1'b1;
      while (exp_q.size() != 0 && n < 100) begin
         @(posedge clk);
         #1;
         n++;
      end
      fifo_read = 1'b0;
      if (exp_q.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL drain_timeout: %0d words left at %0t", exp_q.size(), $time);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic do_clear();
      clear         = 1'b1;
      s_axis.tdata  = {$urandom, $urandom};
      s_axis.tlast  = 1'b0;
      s_axis.tvalid = 1'b1;
      @(posedge clk);
      #1;
      clear         = 1'b0;
      s_axis.tvalid = 1'b0;
      model_flush();
   endtask

   // scoreboard monitor
   always @(negedge clk) begin
      if (sb_en) begin
         check64("fifo_cnt", 64'(fifo_cnt), 64'(exp_q.size()));
`ifdef WEIGHT_PRELOAD_STATUS_EN
         check64("words_rcvd", 64'(words_rcvd), 64'(exp_words));
         check64("err_short_pkt", 64'(err_short_pkt), 64'(exp_err));
`else
         check64("words_rcvd", 64'(words_rcvd), 64'd0);
         check64("err_short_pkt", 64'(err_short_pkt), 64'd0);
`endif
         if (exp_q.size() == 0) begin
            check_word("fifo_data_empty", fifo_data, '0);
         end else if (fifo_read && !clear) begin
            check_word("fifo_data_head", fifo_data, exp_q[0]);
            void'(exp_q.pop_front());
         end
      end
   end

   initial begin
      logic [W-1:0] ones_lo;
      int nbeats;
      checks        = 0;
      errors        = 0;
      sb_en         = 1'b0;
      rand_done     = 1'b0;
      rst_n         = 1'b0;
      clear         = 1'b0;
      fifo_read     = 1'b0;
      s_axis.tdata  = '0;
      s_axis.tvalid = 1'b0;
      s_axis.tlast  = 1'b0;
      model_flush();
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      sb_en = 1'b1;
      @(negedge clk);
      check64("reset_tready", 64'(s_axis.tready), 64'd1);
      @(posedge clk);
      #1;

      // single word with data = beat index
      for (int k = 0; k < BEATS; k++) send_beat(64'(k), k == BEATS - 1);
      @(negedge clk);
      check64("single_cnt", 64'(fifo_cnt), 64'd1);
      check64("single_lo", fifo_data[63:0], 64'd0);
      check64("single_hi", fifo_data[1279:1216], 64'd19);
      @(posedge clk);
      #1;
      drain();

      // fill and stall on the final beat of word 5
      for (int i = 0; i < DEPTH; i++) send_word_rand();
      for (int k = 0; k < BEATS - 1; k++) send_beat({$urandom, $urandom}, 1'b0);
      s_axis.tdata  = 64'hC0DE_0000_0000_0013;
      s_axis.tlast  = 1'b1;
      s_axis.tvalid = 1'b1;
      repeat (5) begin
         @(negedge clk);
         check64("stall_tready", 64'(s_axis.tready), 64'd0);
      end
      @(posedge clk);
      #1;
      fifo_read = 1'b1;
      @(posedge clk);
      #1;
      fifo_read = 1'b0;
      send_beat(64'hC0DE_0000_0000_0013, 1'b1);
      @(negedge clk);
      check64("stall_cnt_after", 64'(fifo_cnt), 64'd4);
      @(posedge clk);
      #1;
      drain();

      // consumer polls an empty FIFO, then two words arrive
      fifo_read = 1'b1;
      repeat (10) @(posedge clk);
      #1;
      send_word_rand();
      send_word_rand();
      repeat (3) @(posedge clk);
      #1;
      fifo_read = 1'b0;
      check64("poll_drained", 64'(exp_q.size()), 64'd0);

      // simultaneous push and pop at two words
      send_word_rand();
      send_word_rand();
      for (int k = 0; k < BEATS - 1; k++) send_beat({$urandom, $urandom}, 1'b0);
      fifo_read = 1'b1;
      send_beat({$urandom, $urandom}, 1'b1);
      fifo_read = 1'b0;
      @(negedge clk);
      check64("pushpop_cnt", 64'(fifo_cnt), 64'd2);
      check_word("pushpop_head", fifo_data, exp_q[0]);
      @(posedge clk);
      #1;
      drain();

      // short packet: tlast on beat 7
      for (int k = 0; k < 8; k++) send_beat(64'hFFFF_FFFF_FFFF_FFFF, k == 7);
      @(negedge clk);
      ones_lo = '0;
      ones_lo[511:0] = '1;
      check_word("short_word", fifo_data, ones_lo);
`ifdef WEIGHT_PRELOAD_STATUS_EN
      check64("short_err", 64'(err_short_pkt), 64'd1);
`endif
      @(posedge clk);
      #1;
      drain();

      // clear mid-word with three words queued
      for (int i = 0; i < 3; i++) send_word_rand();
      for (int k = 0; k < 11; k++) send_beat({$urandom, $urandom}, 1'b0);
      do_clear();
      @(negedge clk);
      check64("clear_cnt", 64'(fifo_cnt), 64'd0);
      check64("clear_words", 64'(words_rcvd), 64'd0);
      @(posedge clk);
      #1;
      for (int k = 0; k < BEATS; k++) send_beat(64'(k + 100), k == BEATS - 1);
      @(negedge clk);
      check64("after_clear_lo", fifo_data[63:0], 64'd100);
      check64("after_clear_hi", fifo_data[1279:1216], 64'd119);
      @(posedge clk);
      #1;
      drain();

      // randomized traffic with a random consumer
      fork
         begin
            for (int p = 0; p < 30; p++) begin
               case ($urandom_range(0, 2))
                  0:       nbeats = BEATS * $urandom_range(1, 2);
                  1:       nbeats = $urandom_range(1, BEATS - 1);
                  default: nbeats = BEATS + $urandom_range(1, BEATS - 1);
               endcase
               for (int k = 0; k < nbeats; k++) begin
                  if (k == nbeats - 1 && (nbeats % BEATS) != 0) wait_room();
                  send_beat({$urandom, $urandom}, k == nbeats - 1);
               end
               repeat ($urandom_range(0, 3)) @(posedge clk);
               #1;
            end
            rand_done = 1'b1;
         end
         begin
            while (!rand_done) begin
               fifo_read = ($urandom_range(0, 2) == 0);
               @(posedge clk);
               #1;
            end
            fifo_read = 1'b0;
         end
      join
      drain();

      // reset in the middle of a packet
      for (int k = 0; k < 5; k++) send_beat({$urandom, $urandom}, 1'b0);
      sb_en = 1'b0;
      rst_n = 1'b0;
      model_flush();
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      sb_en = 1'b1;
      @(negedge clk);
      check64("rst_mid_tready", 64'(s_axis.tready), 64'd1);
      check64("rst_mid_cnt", 64'(fifo_cnt), 64'd0);
      @(posedge clk);
      #1;
      for (int k = 0; k < BEATS; k++) send_beat(64'(k + 7), k == BEATS - 1);
      @(negedge clk);
      check64("rst_mid_lo", fifo_data[63:0], 64'd7);
      @(posedge clk);
      #1;
      drain();

      sb_en = 1'b0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
